// File: rtl/data_mem_initiator.sv
// data_mem_initiator
//   Single-outstanding load/store initiator between a load/store client and
//   the data memory port. A command is accepted, checked for alignment,
//   issued as one req/gnt/rvalid transaction and answered with one response.
//   Byte enables and lane-replicated write data are built at accept time.
//   Load data is extracted from the addressed lane and sign/zero extended.
//
// Ports
//   clk, rst_n                 clock, async active-low reset
//   cmd_valid_i / cmd_ready_o  command handshake
//   cmd_we_i, cmd_size_i, cmd_signed_i, cmd_addr_i, cmd_wdata_i  command
//   rsp_valid_o / rsp_ready_i  response handshake
//   rsp_rdata_o, rsp_err_o     response payload
//   data_req_o, data_addr_o, data_we_o, data_be_o, data_wdata_o  bus request
//   data_gnt_i, data_rvalid_i, data_rdata_i, data_err_i          bus replies
//   busy_o                     any state other than IDLE
module data_mem_initiator #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_we_i,
  input  logic [1:0]            cmd_size_i,
  input  logic                  cmd_signed_i,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [DATA_WIDTH-1:0] cmd_wdata_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic                  data_req_o,
  output logic [ADDR_WIDTH-1:0] data_addr_o,
  output logic                  data_we_o,
  output logic [3:0]            data_be_o,
  output logic [DATA_WIDTH-1:0] data_wdata_o,
  input  logic                  data_gnt_i,
  input  logic                  data_rvalid_i,
  input  logic [DATA_WIDTH-1:0] data_rdata_i,
  input  logic                  data_err_i,
  output logic                  busy_o
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_e;

  state_e                  state_q;
  logic                    we_q, signed_q;
  logic [1:0]              size_q, off_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [3:0]              be_q;
  logic [DATA_WIDTH-1:0]   wdata_q, rdata_q;
  logic                    err_q;
  logic [CW-1:0]           cnt_q;

  logic                    legal_d;
  logic [3:0]              be_d;
  logic [DATA_WIDTH-1:0]   wdata_d, rdata_d;
  logic [7:0]              rbyte;
  logic [15:0]             rhalf;

  // Command decode: alignment check, byte enables, lane replication.
  always_comb begin
    legal_d = 1'b0;
    be_d    = 4'b0000;
    wdata_d = cmd_wdata_i;
    case (cmd_size_i)
      2'b00: begin
        legal_d = 1'b1;
        be_d    = 4'b0001 << cmd_addr_i[1:0];
        wdata_d = {4{cmd_wdata_i[7:0]}};
      end
      2'b01: begin
        legal_d = ~cmd_addr_i[0];
        be_d    = 4'b0011 << cmd_addr_i[1:0];
        wdata_d = {2{cmd_wdata_i[15:0]}};
      end
      2'b10: begin
        legal_d = (cmd_addr_i[1:0] == 2'b00);
        be_d    = 4'b1111;
      end
      default: legal_d = 1'b0;
    endcase
  end

  // Load lane extraction and extension from the latched command.
  always_comb begin
    rbyte = data_rdata_i[{off_q, 3'b000} +: 8];
    rhalf = off_q[1] ? data_rdata_i[31:16] : data_rdata_i[15:0];
    case (size_q)
      2'b00:   rdata_d = {{24{signed_q & rbyte[7]}}, rbyte};
      2'b01:   rdata_d = {{16{signed_q & rhalf[15]}}, rhalf};
      default: rdata_d = data_rdata_i;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      signed_q <= 1'b0;
      size_q   <= 2'b00;
      off_q    <= 2'b00;
      addr_q   <= '0;
      be_q     <= 4'b0000;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      case (state_q)
        IDLE: if (cmd_valid_i) begin
          we_q     <= cmd_we_i;
          signed_q <= cmd_signed_i;
          size_q   <= cmd_size_i;
          off_q    <= cmd_addr_i[1:0];
          addr_q   <= {cmd_addr_i[ADDR_WIDTH-1:2], 2'b00};
          be_q     <= be_d;
          wdata_q  <= wdata_d;
          rdata_q  <= '0;
          cnt_q    <= '0;
          // Illegal commands answer directly without touching the bus.
          err_q    <= ~legal_d;
          state_q  <= legal_d ? REQ : RESP;
        end
        REQ: begin
          // A grant in the timeout cycle still wins.
          if (data_gnt_i) begin
            cnt_q   <= '0;
            state_q <= WAIT;
          end else if (cnt_q == CNT_MAX) begin
            err_q   <= 1'b1;
            state_q <= RESP;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        WAIT: begin
          if (data_rvalid_i) begin
            rdata_q <= (we_q || data_err_i) ? '0 : rdata_d;
            err_q   <= data_err_i;
            state_q <= RESP;
          end else if (cnt_q == CNT_MAX) begin
            err_q   <= 1'b1;
            state_q <= RESP;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        RESP: if (rsp_ready_i) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_ready_o  = (state_q == IDLE);
  assign busy_o       = (state_q != IDLE);
  assign data_req_o   = (state_q == REQ);
  assign rsp_valid_o  = (state_q == RESP);
  assign rsp_rdata_o  = rdata_q;
  assign rsp_err_o    = err_q;
  assign data_addr_o  = addr_q;
  assign data_we_o    = we_q;
  assign data_be_o    = be_q;
  assign data_wdata_o = wdata_q;

endmodule

// File: tb/tb_data_mem_initiator.sv
module tb_data_mem_initiator;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid_i = 1'b0, cmd_we_i = 1'b0, cmd_signed_i = 1'b0;
  logic [1:0]  cmd_size_i = 2'b00;
  logic [7:0]  cmd_addr_i = 8'h00;
  logic [31:0] cmd_wdata_i = 32'h0;
  logic        rsp_ready_i = 1'b0;
  logic        data_gnt_i = 1'b0, data_rvalid_i = 1'b0, data_err_i = 1'b0;
  logic [31:0] data_rdata_i = 32'h0;
  logic        cmd_ready_o, rsp_valid_o, rsp_err_o, data_req_o, data_we_o, busy_o;
  logic [31:0] rsp_rdata_o, data_wdata_o;
  logic [7:0]  data_addr_o;
  logic [3:0]  data_be_o;

  data_mem_initiator #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .TIMEOUT(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
    .cmd_size_i(cmd_size_i), .cmd_signed_i(cmd_signed_i), .cmd_addr_i(cmd_addr_i),
    .cmd_wdata_i(cmd_wdata_i), .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o), .data_req_o(data_req_o),
    .data_addr_o(data_addr_o), .data_we_o(data_we_o), .data_be_o(data_be_o),
    .data_wdata_o(data_wdata_o), .data_gnt_i(data_gnt_i), .data_rvalid_i(data_rvalid_i),
    .data_rdata_i(data_rdata_i), .data_err_i(data_err_i), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  typedef struct { logic [31:0] rdata; logic err; } exp_t;
  exp_t sb[$];

  // Bus slave controls (written by the sequencer only).
  bit gnt_en = 1'b1, rv_en = 1'b1, err_inj = 1'b0;
  int gnt_delay = 0;
  // Bus slave state (written by the slave only).
  logic [31:0] mem [64] = '{0: 32'hB000B1E5, 1: 32'hB001B1E5, default: 32'h0};
  bit          pending = 1'b0;
  int          req_run = 0, req_cycles = 0;
  logic [7:0]  cap_addr = 8'h0;
  logic [3:0]  cap_be = 4'h0;
  logic [31:0] cap_wd = 32'h0;
  logic        cap_we = 1'b0;

  // Memory responder: grant after gnt_delay request cycles, complete the
  // cycle after grant, applying byte enables on stores.
  always @(negedge clk) begin
    data_gnt_i    = 1'b0;
    data_rvalid_i = 1'b0;
    data_err_i    = 1'b0;
    data_rdata_i  = 32'h0;
    if (!busy_o) pending = 1'b0;
    if (data_req_o) begin req_run++; req_cycles++; end
    else req_run = 0;
    if (pending) begin
      if (rv_en) begin
        data_rvalid_i = 1'b1;
        data_err_i    = err_inj;
        data_rdata_i  = mem[cap_addr[7:2]];
        if (cap_we)
          for (int b = 0; b < 4; b++)
            if (cap_be[b]) mem[cap_addr[7:2]][b*8 +: 8] = cap_wd[b*8 +: 8];
        pending = 1'b0;
      end
    end else if (data_req_o && gnt_en && req_run > gnt_delay) begin
      data_gnt_i = 1'b1;
      pending    = 1'b1;
      cap_addr   = data_addr_o;
      cap_be     = data_be_o;
      cap_wd     = data_wdata_o;
      cap_we     = data_we_o;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one command, push its expected response, then pop and compare when
  // the DUT answers. exp_lat = expected cycles from accept to rsp_valid_o.
  task automatic do_cmd(input logic we, input logic [1:0] size, input logic sgn,
                        input logic [7:0] addr, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_err,
                        input int exp_lat, input int hold);
    exp_t e;
    int lat;
    logic [31:0] rd0;
    sb.push_back('{exp_rd, exp_err});
    @(negedge clk);
    chk("cmd_ready_idle", 32'(cmd_ready_o), 32'd1);
    cmd_we_i = we; cmd_size_i = size; cmd_signed_i = sgn;
    cmd_addr_i = addr; cmd_wdata_i = wd; cmd_valid_i = 1'b1;
    @(posedge clk);
    #1 cmd_valid_i = 1'b0;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!rsp_valid_o && lat < 200);
    chk("rsp_latency", 32'(lat), 32'(exp_lat));
    e = sb.pop_front();
    chk("rsp_rdata", rsp_rdata_o, e.rdata);
    chk("rsp_err", 32'(rsp_err_o), 32'(e.err));
    chk("cmd_ready_busy", 32'(cmd_ready_o), 32'd0);
    rd0 = rsp_rdata_o;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", 32'(rsp_valid_o), 32'd1);
      chk("hold_rdata", rsp_rdata_o, rd0);
      chk("hold_ready", 32'(cmd_ready_o), 32'd0);
    end
    rsp_ready_i = 1'b1;
    @(posedge clk);
    #1 rsp_ready_i = 1'b0;
    chk("ready_after_rsp", 32'(cmd_ready_o), 32'd1);
  endtask

  task automatic chk_bus(input logic [7:0] a, input logic [3:0] be, input logic [31:0] wd);
    chk("bus_addr", 32'(cap_addr), 32'(a));
    chk("bus_be", 32'(cap_be), 32'(be));
    if (cap_we) chk("bus_wdata", cap_wd, wd);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_ctl"}, 32'({cmd_ready_o, busy_o, data_req_o, data_we_o, rsp_valid_o, rsp_err_o}),
        32'b100000);
    chk({tag, "_addr_be"}, 32'({data_addr_o, data_be_o}), 32'd0);
    chk({tag, "_wdata"}, data_wdata_o, 32'd0);
    chk({tag, "_rdata"}, rsp_rdata_o, 32'd0);
  endtask

  initial begin
    int rc;
    repeat (2) @(negedge clk);
    chk_reset_outs("reset");
    rst_n = 1'b1;

    // Loads on word 0 = B000B1E5.
    do_cmd(0, 2'b00, 1, 8'h01, 0, 32'hFFFFFFB1, 0, 3, 0);
    chk_bus(8'h00, 4'b0010, 0);
    do_cmd(0, 2'b01, 0, 8'h02, 0, 32'h0000B000, 0, 3, 0);
    chk_bus(8'h00, 4'b1100, 0);
    do_cmd(0, 2'b01, 1, 8'h02, 0, 32'hFFFFB000, 0, 3, 0);

    // Store byte then read back the word; hold the response 5 cycles.
    do_cmd(1, 2'b00, 0, 8'h07, 32'h000000A5, 32'h0, 0, 3, 0);
    chk_bus(8'h04, 4'b1000, 32'hA5A5A5A5);
    do_cmd(0, 2'b10, 0, 8'h04, 0, 32'hA501B1E5, 0, 3, 5);

    // Illegal commands answer in cycle 1 with no bus request.
    rc = req_cycles;
    do_cmd(0, 2'b10, 0, 8'h02, 0, 32'h0, 1, 1, 0);
    do_cmd(0, 2'b11, 0, 8'h00, 0, 32'h0, 1, 1, 0);
    do_cmd(1, 2'b01, 0, 8'h03, 32'h1234, 32'h0, 1, 1, 0);
    chk("illegal_no_req", 32'(req_cycles - rc), 32'd0);

    // Grant timeout: 64 request cycles, then error.
    gnt_en = 1'b0;
    rc = req_cycles;
    do_cmd(0, 2'b10, 0, 8'h00, 0, 32'h0, 1, 65, 0);
    chk("gnt_timeout_req_cycles", 32'(req_cycles - rc), 32'd64);
    gnt_en = 1'b1;

    // Completion timeout: 64 WAIT cycles, then error.
    rv_en = 1'b0;
    do_cmd(0, 2'b10, 0, 8'h00, 0, 32'h0, 1, 66, 0);
    rv_en = 1'b1;

    // Grant in the final timeout cycle wins.
    gnt_delay = 63;
    do_cmd(0, 2'b10, 0, 8'h04, 0, 32'hA501B1E5, 0, 66, 0);
    gnt_delay = 0;

    // Bus error on completion.
    err_inj = 1'b1;
    do_cmd(0, 2'b10, 0, 8'h00, 0, 32'h0, 1, 3, 0);
    err_inj = 1'b0;

    // Halfword store, then word and byte readback.
    do_cmd(1, 2'b01, 0, 8'h0A, 32'hFFFF1234, 32'h0, 0, 3, 0);
    chk_bus(8'h08, 4'b1100, 32'h12341234);
    do_cmd(0, 2'b10, 0, 8'h08, 0, 32'h12340000, 0, 3, 0);
    do_cmd(0, 2'b00, 0, 8'h0B, 0, 32'h00000012, 0, 3, 0);

    // Reset while in WAIT (a store, so latched state is nonzero).
    rv_en = 1'b0;
    @(negedge clk);
    cmd_we_i = 1; cmd_size_i = 2'b10; cmd_signed_i = 0;
    cmd_addr_i = 8'h0C; cmd_wdata_i = 32'hDEADBEEF; cmd_valid_i = 1'b1;
    @(posedge clk);
    #1 cmd_valid_i = 1'b0;
    @(negedge clk);
    chk("rst_test_req", 32'(data_req_o), 32'd1);
    @(negedge clk);
    chk("rst_test_wait", 32'({busy_o, data_req_o}), 32'b10);
    #2 rst_n = 1'b0;
    #1 chk_reset_outs("reset_in_wait");
    @(negedge clk);
    rst_n = 1'b1;
    rv_en = 1'b1;

    // Normal operation after reset.
    do_cmd(0, 2'b01, 1, 8'h00, 0, 32'hFFFFB1E5, 0, 3, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
endmodule
